// File: rtl/mem_requester_if.sv
// Client command/response and controller request/return bundle for mem_requester.
// master = the requester block, slave = traffic source plus memory controller side.
interface mem_requester_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [15:0]   cmd_address;
  logic [15:0]   cmd_data;

  logic [15:0]   wr_address;
  logic [15:0]   wr_data;
  logic          wr_en;
  logic [15:0]   wr_ret_address;
  logic          wr_ret_ack;

  logic [15:0]   rd_address;
  logic          rd_en;
  logic [15:0]   rd_ret_data;
  logic [15:0]   rd_ret_address;
  logic          rd_ret_ack;

  logic          rd_resp_valid;
  logic [15:0]   rd_resp_address;
  logic [15:0]   rd_resp_data;
  logic          wr_resp_valid;
  logic [15:0]   wr_resp_address;

  logic [CW-1:0] outstanding;
  logic          err_unexpected;
  logic          err_timeout;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_data,
    input  wr_ret_address, wr_ret_ack,
    input  rd_ret_data, rd_ret_address, rd_ret_ack,
    output cmd_ready,
    output wr_address, wr_data, wr_en,
    output rd_address, rd_en,
    output rd_resp_valid, rd_resp_address, rd_resp_data,
    output wr_resp_valid, wr_resp_address,
    output outstanding, err_unexpected, err_timeout
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_data,
    output wr_ret_address, wr_ret_ack,
    output rd_ret_data, rd_ret_address, rd_ret_ack,
    input  cmd_ready,
    input  wr_address, wr_data, wr_en,
    input  rd_address, rd_en,
    input  rd_resp_valid, rd_resp_address, rd_resp_data,
    input  wr_resp_valid, wr_resp_address,
    input  outstanding, err_unexpected, err_timeout
  );
endinterface

// File: rtl/mem_requester.sv
// Initiator front end: issues client commands to the memory controller and matches
// address-tagged, possibly out-of-order returns against a table of outstanding requests.
module mem_requester #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_requester_if.master bus
);
  localparam int IW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int AGEW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AGEW-1:0] AGE_MAX = AGEW'(TIMEOUT);
  localparam logic [AGEW-1:0] AGE_PRE = AGEW'(TIMEOUT - 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] is_wr_q, is_wr_d;
  logic [15:0]      addr_q [DEPTH];
  logic [15:0]      addr_d [DEPTH];
  logic [AGEW-1:0]  age_q  [DEPTH];
  logic [AGEW-1:0]  age_d  [DEPTH];

  logic [DEPTH-1:0] coll_vec, rd_hit_vec, wr_hit_vec, age_hit_vec;
  logic [IW-1:0]    alloc_idx;
  logic             cmd_ready;
  logic             accept;
  logic             rd_hit, wr_hit;
  logic [CW-1:0]    outstanding_q, outstanding_d;

  logic             wr_en_q, rd_en_q;
  logic [15:0]      wr_address_q, wr_data_q, rd_address_q;
  logic             rd_resp_valid_q, wr_resp_valid_q;
  logic [15:0]      rd_resp_address_q, rd_resp_data_q, wr_resp_address_q;
  logic             err_unexpected_q, err_timeout_q;

  // Addresses are unique in the table, so each return hits at most one entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign coll_vec[gi]    = valid_q[gi] && (addr_q[gi] == bus.cmd_address);
      assign rd_hit_vec[gi]  = bus.rd_ret_ack && valid_q[gi] && !is_wr_q[gi] &&
                               (addr_q[gi] == bus.rd_ret_address);
      assign wr_hit_vec[gi]  = bus.wr_ret_ack && valid_q[gi] && is_wr_q[gi] &&
                               (addr_q[gi] == bus.wr_ret_address);
      assign age_hit_vec[gi] = valid_q[gi] && (age_q[gi] == AGE_PRE);
    end
  endgenerate

  assign rd_hit    = |rd_hit_vec;
  assign wr_hit    = |wr_hit_vec;
  assign cmd_ready = rst_n && !(&valid_q) && !(|coll_vec);
  assign accept    = bus.cmd_valid && cmd_ready;

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IW'(i);
    end
  end

  // Entries freed this cycle are never allocated on the same edge: allocation
  // only looks at entries that were already free before the edge.
  always_comb begin
    valid_d = valid_q & ~rd_hit_vec & ~wr_hit_vec;
    is_wr_d = is_wr_q;
    for (int i = 0; i < DEPTH; i++) begin
      addr_d[i] = addr_q[i];
      age_d[i]  = (valid_q[i] && (age_q[i] != AGE_MAX)) ? age_q[i] + AGEW'(1) : age_q[i];
    end
    if (accept) begin
      valid_d[alloc_idx] = 1'b1;
      is_wr_d[alloc_idx] = bus.cmd_write;
      addr_d[alloc_idx]  = bus.cmd_address;
      age_d[alloc_idx]   = '0;
    end
  end

  assign outstanding_d = outstanding_q + CW'(accept) - CW'(rd_hit) - CW'(wr_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q           <= '0;
      is_wr_q           <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        age_q[i]  <= '0;
      end
      outstanding_q     <= '0;
      wr_en_q           <= 1'b0;
      rd_en_q           <= 1'b0;
      wr_address_q      <= '0;
      wr_data_q         <= '0;
      rd_address_q      <= '0;
      rd_resp_valid_q   <= 1'b0;
      rd_resp_address_q <= '0;
      rd_resp_data_q    <= '0;
      wr_resp_valid_q   <= 1'b0;
      wr_resp_address_q <= '0;
      err_unexpected_q  <= 1'b0;
      err_timeout_q     <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      is_wr_q       <= is_wr_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        age_q[i]  <= age_d[i];
      end
      outstanding_q <= outstanding_d;

      wr_en_q <= accept && bus.cmd_write;
      rd_en_q <= accept && !bus.cmd_write;
      if (accept && bus.cmd_write) begin
        wr_address_q <= bus.cmd_address;
        wr_data_q    <= bus.cmd_data;
      end
      if (accept && !bus.cmd_write) begin
        rd_address_q <= bus.cmd_address;
      end

      rd_resp_valid_q <= rd_hit;
      if (rd_hit) begin
        rd_resp_address_q <= bus.rd_ret_address;
        rd_resp_data_q    <= bus.rd_ret_data;
      end
      wr_resp_valid_q <= wr_hit;
      if (wr_hit) begin
        wr_resp_address_q <= bus.wr_ret_address;
      end

      if ((bus.rd_ret_ack && !rd_hit) || (bus.wr_ret_ack && !wr_hit)) begin
        err_unexpected_q <= 1'b1;
      end
      if (|age_hit_vec) begin
        err_timeout_q <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready       = cmd_ready;
  assign bus.wr_en           = wr_en_q;
  assign bus.wr_address      = wr_address_q;
  assign bus.wr_data         = wr_data_q;
  assign bus.rd_en           = rd_en_q;
  assign bus.rd_address      = rd_address_q;
  assign bus.rd_resp_valid   = rd_resp_valid_q;
  assign bus.rd_resp_address = rd_resp_address_q;
  assign bus.rd_resp_data    = rd_resp_data_q;
  assign bus.wr_resp_valid   = wr_resp_valid_q;
  assign bus.wr_resp_address = wr_resp_address_q;
  assign bus.outstanding     = outstanding_q;
  assign bus.err_unexpected  = err_unexpected_q;
  assign bus.err_timeout     = err_timeout_q;
endmodule

// File: tb/tb_mem_requester.sv
// Scoreboard bench for mem_requester: a queue-based model of outstanding requests
// predicts requests, responses, ready, occupancy and error flags.
module tb_mem_requester;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_requester_if #(.DEPTH(DEPTH)) bus ();

  mem_requester #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; } req_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; } resp_t;
  typedef struct { logic [15:0] addr; bit wr; int acc; } ent_t;

  req_t        exp_req_q[$];
  resp_t       exp_rd_q[$];
  logic [15:0] exp_wr_q[$];
  ent_t        pend[$];

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int exp_out = 0;
  bit exp_err_u = 1'b0;
  bit exp_err_t = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int find(input logic [15:0] a, input bit wr, input bit any_dir);
    for (int i = 0; i < pend.size(); i++)
      if (pend[i].addr == a && (any_dir || pend[i].wr == wr)) return i;
    return -1;
  endfunction

  // One clock of stimulus; the model is advanced using the pre-edge table contents.
  task automatic cycle(input bit cv, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                       input bit rack, input logic [15:0] ra, input logic [15:0] rd,
                       input bit wack, input logic [15:0] wa);
    bit    exp_rdy;
    int    ri, wi;
    ent_t  e;
    req_t  r;
    resp_t p;
    @(negedge clk);
    bus.cmd_valid      = cv;
    bus.cmd_write      = cw;
    bus.cmd_address    = ca;
    bus.cmd_data       = cd;
    bus.rd_ret_ack     = rack;
    bus.rd_ret_address = ra;
    bus.rd_ret_data    = rd;
    bus.wr_ret_ack     = wack;
    bus.wr_ret_address = wa;
    #1;
    exp_rdy = (pend.size() < DEPTH) && (find(ca, 1'b0, 1'b1) < 0);
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(exp_rdy));
    foreach (pend[i]) if (cyc - pend[i].acc >= TIMEOUT) exp_err_t = 1'b1;
    ri = rack ? find(ra, 1'b0, 1'b0) : -1;
    wi = wack ? find(wa, 1'b1, 1'b0) : -1;
    if (rack && ri < 0) exp_err_u = 1'b1;
    if (wack && wi < 0) exp_err_u = 1'b1;
    if (ri >= 0) begin p.addr = ra; p.data = rd; exp_rd_q.push_back(p); end
    if (wi >= 0) exp_wr_q.push_back(wa);
    if (ri > wi) begin
      pend.delete(ri);
      if (wi >= 0) pend.delete(wi);
    end else begin
      if (wi >= 0) pend.delete(wi);
      if (ri >= 0) pend.delete(ri);
    end
    if (cv && exp_rdy) begin
      e.addr = ca; e.wr = cw; e.acc = cyc;
      pend.push_back(e);
      r.wr = cw; r.addr = ca; r.data = cd;
      exp_req_q.push_back(r);
    end
    exp_out = pend.size();
    cyc++;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 16'hFFFF, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic rd_cmd(input logic [15:0] a);
    cycle(1'b1, 1'b0, a, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  // Returns a random outstanding address of the given direction, if any.
  function automatic bit pick(input bit wr, output logic [15:0] a);
    int c[$];
    a = 16'h0;
    foreach (pend[i]) if (pend[i].wr == wr) c.push_back(i);
    if (c.size() == 0) return 1'b0;
    a = pend[c[$urandom_range(0, c.size() - 1)]].addr;
    return 1'b1;
  endfunction

  task automatic drain();
    logic [15:0] ra, wa;
    bit rk, wk;
    for (int k = 0; k < 40 && pend.size() > 0; k++) begin
      rk = pick(1'b0, ra);
      wk = pick(1'b1, wa);
      cycle(1'b0, 1'b0, 16'hFFFF, 16'h0, rk, ra, 16'($urandom), wk, wa);
    end
    chk("drain_empty", 32'(pend.size()), 32'd0);
    idle();
  endtask

  // Monitor: checks whatever the DUT presents one step after each rising edge.
  initial begin
    req_t  r;
    resp_t p;
    logic [15:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (bus.wr_en || bus.rd_en) begin
          if (exp_req_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL req_extra: got wr_en=%0b rd_en=%0b, expected no request", bus.wr_en, bus.rd_en);
          end else begin
            r = exp_req_q.pop_front();
            chk("req_wr_en", 32'(bus.wr_en), 32'(r.wr));
            chk("req_rd_en", 32'(bus.rd_en), 32'(!r.wr));
            if (r.wr) begin
              chk("wr_address", 32'(bus.wr_address), 32'(r.addr));
              chk("wr_data", 32'(bus.wr_data), 32'(r.data));
            end else begin
              chk("rd_address", 32'(bus.rd_address), 32'(r.addr));
            end
            $display("req %s addr=%04h data=%04h", r.wr ? "WR" : "RD", r.addr, r.data);
          end
        end
        chk("req_missing", 32'(exp_req_q.size()), 32'd0);
        exp_req_q.delete();
        if (bus.rd_resp_valid) begin
          if (exp_rd_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL rd_resp_extra: got addr=%04h, expected no response", bus.rd_resp_address);
          end else begin
            p = exp_rd_q.pop_front();
            chk("rd_resp_address", 32'(bus.rd_resp_address), 32'(p.addr));
            chk("rd_resp_data", 32'(bus.rd_resp_data), 32'(p.data));
            $display("rd_resp addr=%04h data=%04h", p.addr, p.data);
          end
        end
        chk("rd_resp_missing", 32'(exp_rd_q.size()), 32'd0);
        exp_rd_q.delete();
        if (bus.wr_resp_valid) begin
          if (exp_wr_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL wr_resp_extra: got addr=%04h, expected no response", bus.wr_resp_address);
          end else begin
            w = exp_wr_q.pop_front();
            chk("wr_resp_address", 32'(bus.wr_resp_address), 32'(w));
            $display("wr_resp addr=%04h", w);
          end
        end
        chk("wr_resp_missing", 32'(exp_wr_q.size()), 32'd0);
        exp_wr_q.delete();
        chk("outstanding", 32'(bus.outstanding), 32'(exp_out));
        chk("err_unexpected", 32'(bus.err_unexpected), 32'(exp_err_u));
        chk("err_timeout", 32'(bus.err_timeout), 32'(exp_err_t));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    chk({tag, "_outstanding"}, 32'(bus.outstanding), 32'd0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    chk({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
    chk({tag, "_rd_address"}, 32'(bus.rd_address), 32'd0);
    chk({tag, "_rd_resp_valid"}, 32'(bus.rd_resp_valid), 32'd0);
    chk({tag, "_wr_resp_valid"}, 32'(bus.wr_resp_valid), 32'd0);
    chk({tag, "_err_unexpected"}, 32'(bus.err_unexpected), 32'd0);
    chk({tag, "_err_timeout"}, 32'(bus.err_timeout), 32'd0);
  endtask

  task automatic model_reset();
    pend.delete();
    exp_req_q.delete();
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_out = 0;
    exp_err_u = 1'b0;
    exp_err_t = 1'b0;
  endtask

  task automatic quiet_inputs();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_address = 16'h0; bus.cmd_data = 16'h0;
    bus.rd_ret_ack = 1'b0; bus.rd_ret_address = 16'h0; bus.rd_ret_data = 16'h0;
    bus.wr_ret_ack = 1'b0; bus.wr_ret_address = 16'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, wa;
    bit rk, wk;
    quiet_inputs();
    rst_n = 1'b0;
    #3;
    bus.cmd_valid = 1'b1;
    #1;
    chk_all_zero("reset");
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read
    rd_cmd(16'h0010);
    idle();
    cycle(1'b0, 1'b0, 16'hFFFF, 16'h0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0);
    idle();

    // Fill, then drain out of order while a command waits
    rd_cmd(16'h1); rd_cmd(16'h2); rd_cmd(16'h3); rd_cmd(16'h4);
    rd_cmd(16'h5);
    cycle(1'b0, 1'b0, 16'h5, 16'h0, 1'b1, 16'h3, 16'hA003, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h5, 16'h0, 1'b1, 16'h1, 16'hA001, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h5, 16'h0, 1'b1, 16'h4, 16'hA004, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h5, 16'h0, 1'b1, 16'h2, 16'hA002, 1'b0, 16'h0);
    idle();

    // Address collision
    cycle(1'b1, 1'b1, 16'h0020, 16'h5A5A, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    rd_cmd(16'h0020);
    rd_cmd(16'h0020);
    cycle(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0020);
    rd_cmd(16'h0020);
    idle();
    cycle(1'b0, 1'b0, 16'hFFFF, 16'h0, 1'b1, 16'h0020, 16'h7777, 1'b0, 16'h0);

    // Simultaneous read return, write return and accept
    rd_cmd(16'h5);
    cycle(1'b1, 1'b1, 16'h6, 16'hC0DE, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    idle();
    cycle(1'b1, 1'b0, 16'h7, 16'h0, 1'b1, 16'h5, 16'h5555, 1'b1, 16'h6);
    idle();
    drain();

    // Randomized traffic over a small address space to force collisions and fills
    for (int k = 0; k < 400; k++) begin
      rk = pick(1'b0, ra) && ($urandom_range(0, 2) != 0);
      wk = pick(1'b1, wa) && ($urandom_range(0, 2) != 0);
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)),
            16'($urandom), rk, ra, 16'($urandom), wk, wa);
    end
    drain();

    // Unexpected returns: unknown address, and right address in the wrong direction
    cycle(1'b1, 1'b1, 16'h0044, 16'h1111, 1'b1, 16'h0BAD, 16'h0, 1'b0, 16'h0);
    idle();
    cycle(1'b0, 1'b0, 16'hFFFF, 16'h0, 1'b1, 16'h0044, 16'h0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'hFFFF, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0044);
    idle();

    // Timeout: one read left unanswered, then completed late
    rd_cmd(16'h0030);
    for (int k = 0; k < TIMEOUT + 5; k++) idle();
    chk("timeout_flag_set", 32'(bus.err_timeout), 32'd1);
    cycle(1'b0, 1'b0, 16'hFFFF, 16'h0, 1'b1, 16'h0030, 16'h1234, 1'b0, 16'h0);
    idle();

    // Asynchronous reset with three reads outstanding and a request on the pins
    rd_cmd(16'h0041); rd_cmd(16'h0042); rd_cmd(16'h0043);
    @(negedge clk);
    quiet_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 16'hFFFF, 16'h0, 1'b1, 16'h0041, 16'h0, 1'b0, 16'h0);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
